// File: rtl/io_bus_initiator.sv
// Host-side master for the 4-bit command / 8-bit data toggle-sync IO bus.
// One request in flight; a completion or timeout is reported as a one-cycle response pulse.
module io_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int SETUP_CYCLES   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [3:0] i_req_cmd,
  input  logic [7:0] i_req_data,
  output logic       o_resp_valid,
  output logic [7:0] o_resp_data,
  output logic       o_resp_err,
  output logic [3:0] o_cmd,
  output logic [7:0] o_data,
  output logic       o_sync,
  input  logic       i_sync,
  input  logic [7:0] i_data,
  output logic       o_busy,
  output logic [7:0] o_timeout_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_SETTLE
  } state_t;

  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] setup_cnt_q, setup_cnt_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] cmd_q, cmd_d;
  logic [7:0] data_q, data_d;
  logic       sync_q, sync_d;
  logic       rvld_q, rvld_d;
  logic       rerr_q, rerr_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] tcnt_q, tcnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      setup_cnt_q <= '0;
      timer_q     <= '0;
      cmd_q       <= '0;
      data_q      <= '0;
      sync_q      <= 1'b0;
      rvld_q      <= 1'b0;
      rerr_q      <= 1'b0;
      rdata_q     <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      timer_q     <= timer_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      sync_q      <= sync_d;
      rvld_q      <= rvld_d;
      rerr_q      <= rerr_d;
      rdata_q     <= rdata_d;
      tcnt_q      <= tcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    timer_d     = timer_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    sync_d      = sync_q;
    rvld_d      = 1'b0;
    rerr_d      = 1'b0;
    rdata_d     = rdata_q;
    tcnt_d      = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          cmd_d       = i_req_cmd;
          data_d      = i_req_data;
          setup_cnt_d = '0;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          // Toggle against the current echo so a stale or late echo cannot desync us.
          sync_d  = ~i_sync;
          timer_d = '0;
          state_d = S_WAIT;
        end else begin
          setup_cnt_d = setup_cnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (i_sync == sync_q) begin
          state_d = S_SETTLE;
        end else if (timer_q == TMO_LAST) begin
          rvld_d  = 1'b1;
          rerr_d  = 1'b1;
          rdata_d = '0;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_SETTLE: begin
        rdata_d = i_data;
        rvld_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_req_ready     = (state_q == S_IDLE);
  assign o_busy          = (state_q != S_IDLE);
  assign o_resp_valid    = rvld_q;
  assign o_resp_err      = rerr_q;
  assign o_resp_data     = rdata_q;
  assign o_cmd           = cmd_q;
  assign o_data          = data_q;
  assign o_sync          = sync_q;
  assign o_timeout_count = tcnt_q;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Bench for io_bus_initiator: a behavioural responder on the bus side and a
// register-file model predicting each response byte, error flag and latency.
module tb_io_bus_initiator;

  localparam int TMO = 64;
  localparam int SU  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_cmd = '0;
  logic [7:0] req_data = '0;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_err;
  logic [3:0] bus_cmd;
  logic [7:0] bus_data;
  logic       bus_sync;
  logic       echo_sync;
  logic [7:0] echo_data;
  logic       busy;
  logic [7:0] tmo_count;

  io_bus_initiator #(.TIMEOUT_CYCLES(TMO), .SETUP_CYCLES(SU)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_cmd(req_cmd), .i_req_data(req_data),
    .o_resp_valid(resp_valid), .o_resp_data(resp_data), .o_resp_err(resp_err),
    .o_cmd(bus_cmd), .o_data(bus_data), .o_sync(bus_sync),
    .i_sync(echo_sync), .i_data(echo_data),
    .o_busy(busy), .o_timeout_count(tmo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int orphan = 0;
  int n_tmo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         t;
    logic       s;
  } rsp_t;
  rsp_t rq[$];

  always @(negedge clk) begin
    if (resp_valid === 1'b1) rq.push_back('{resp_data, resp_err, cyc, bus_sync});
    if (resp_err === 1'b1 && resp_valid !== 1'b1) orphan++;
  end

  // Responder: samples the bus on the falling edge, answers on the next rising edge.
  logic       resp_on = 1'b0;
  logic       stale = 1'b0;
  logic       echo = 1'b0;
  logic [7:0] rdata = '0;
  logic [7:0] rregs [8] = '{8'h11, 8'h22, 8'h33, 8'hA5, 8'h55, 8'h66, 8'h77, 8'h88};
  logic       s_sync = 1'b0;
  logic [3:0] s_cmd = '0;
  logic [7:0] s_dat = '0;

  always @(negedge clk) begin
    s_sync <= bus_sync;
    s_cmd  <= bus_cmd;
    s_dat  <= bus_data;
  end

  always @(posedge clk) begin
    if (resp_on && s_sync != (echo ^ stale)) begin
      echo <= s_sync ^ stale;
      if (s_cmd[3]) begin
        rregs[s_cmd[2:0]] <= s_dat;
        rdata <= s_dat;
      end else begin
        case (s_cmd)
          4'b0001: rdata <= rregs[s_dat[2:0]];
          4'b0100: rdata <= 8'h3C;
          4'b0101: rdata <= s_dat;
          4'b0110: rdata <= ~s_dat;
          default: rdata <= 8'h00;
        endcase
      end
    end
  end

  assign echo_sync = echo ^ stale;
  assign echo_data = rdata;

  // Reference register file, updated in request order.
  logic [7:0] mregs [8] = '{8'h11, 8'h22, 8'h33, 8'hA5, 8'h55, 8'h66, 8'h77, 8'h88};

  function automatic logic [7:0] model_resp(input logic [3:0] c, input logic [7:0] d);
    if (c[3]) begin
      mregs[c[2:0]] = d;
      return d;
    end
    case (c)
      4'b0001: return mregs[d[2:0]];
      4'b0100: return 8'h3C;
      4'b0101: return d;
      4'b0110: return ~d;
      default: return 8'h00;
    endcase
  endfunction

  task automatic issue(input logic [3:0] c, input logic [7:0] d, output int acc);
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = c;
    req_data  = d;
    for (int k = 0; k < 200 && req_ready !== 1'b1; k++) @(negedge clk);
    acc = cyc + 1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int lim, output rsp_t r, output logic ok);
    ok = 1'b0;
    r  = '{8'h00, 1'b0, 0, 1'b0};
    for (int k = 0; k < lim; k++) begin
      if (rq.size() > 0) begin
        r  = rq.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic expect_ok(input string nm, input logic [3:0] c, input logic [7:0] d,
                           input logic chk_lat);
    int acc;
    rsp_t r;
    logic ok;
    logic [7:0] exp;
    exp = model_resp(c, d);
    issue(c, d, acc);
    get_rsp(40, r, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s no response got=none want=%h", nm, exp);
    end else begin
      total++;
      if (r.d !== exp || r.e !== 1'b0) begin
        bad++;
        $display("FAIL %s data/err got=%h/%b want=%h/0", nm, r.d, r.e, exp);
      end
      if (chk_lat) begin
        total++;
        if (r.t - acc !== SU + 3) begin
          bad++;
          $display("FAIL %s latency got=%0d want=%0d", nm, r.t - acc, SU + 3);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [32:0] got;
    #3 rst_n = 1'b0;
    #1;
    got = {req_ready, resp_valid, resp_err, busy, bus_sync, bus_cmd, bus_data, resp_data, tmo_count};
    total++;
    if (got !== {1'b1, 32'h0}) begin
      bad++;
      $display("FAIL reset_values got=%h want=%h", got, {1'b1, 32'h0});
    end
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    resp_on = 1'b1;
  endtask

  task automatic test_read();
    int acc;
    rsp_t r;
    logic ok;
    logic [7:0] exp;
    exp = model_resp(4'b0001, 8'h03);
    issue(4'b0001, 8'h03, acc);
    @(negedge clk);
    total++;
    if ({bus_cmd, bus_data, bus_sync, busy, req_ready} !== {4'h1, 8'h03, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL read_setup cmd/data/sync/busy/rdy got=%h/%h/%b/%b/%b want=1/03/0/1/0",
               bus_cmd, bus_data, bus_sync, busy, req_ready);
    end
    @(negedge clk);
    total++;
    if ({bus_cmd, bus_data, bus_sync} !== {4'h1, 8'h03, 1'b1}) begin
      bad++;
      $display("FAIL read_toggle cmd/data/sync got=%h/%h/%b want=1/03/1", bus_cmd, bus_data, bus_sync);
    end
    get_rsp(40, r, ok);
    total++;
    if (!ok || r.d !== exp || r.e !== 1'b0 || r.t - acc !== SU + 3) begin
      bad++;
      $display("FAIL read_resp ok/data/err/lat got=%b/%h/%b/%0d want=1/%h/0/%0d",
               ok, r.d, r.e, r.t - acc, exp, SU + 3);
    end
  endtask

  task automatic test_write();
    expect_ok("write_reg2", 4'b1010, 8'h5C, 1'b1);
    expect_ok("readback_reg2", 4'b0001, 8'h02, 1'b1);
  endtask

  task automatic test_random();
    logic [3:0] c;
    logic [7:0] d;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0:       c = 4'b0001;
        1:       c = {1'b1, 3'($urandom_range(0, 7))};
        2:       c = 4'b0100;
        3:       c = 4'b0101;
        default: c = 4'b0110;
      endcase
      d = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      expect_ok("random", c, d, 1'b1);
    end
  endtask

  task automatic test_timeout();
    int acc;
    rsp_t r;
    logic ok;
    resp_on = 1'b0;
    issue(4'b0001, 8'h03, acc);
    get_rsp(200, r, ok);
    n_tmo++;
    total++;
    if (!ok || r.e !== 1'b1 || r.d !== 8'h00 || r.t - acc !== SU + TMO) begin
      bad++;
      $display("FAIL timeout ok/err/data/lat got=%b/%b/%h/%0d want=1/1/00/%0d",
               ok, r.e, r.d, r.t - acc, SU + TMO);
    end
    total++;
    if (tmo_count !== 8'(n_tmo)) begin
      bad++;
      $display("FAIL timeout_count got=%0d want=%0d", tmo_count, n_tmo);
    end
    resp_on = 1'b1;
    repeat (3) @(negedge clk);
    expect_ok("after_timeout", 4'b0001, 8'h02, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] c [3];
    logic [7:0] d [3];
    logic [7:0] e [3];
    logic s0;
    rsp_t r;
    logic ok;
    int k;
    c = '{4'b1101, 4'b0001, 4'b0110};
    d = '{8'($urandom_range(0, 255)), 8'h05, 8'($urandom_range(0, 255))};
    for (int i = 0; i < 3; i++) e[i] = model_resp(c[i], d[i]);
    @(negedge clk);
    s0 = bus_sync;
    req_valid = 1'b1;
    req_cmd   = c[0];
    req_data  = d[0];
    for (int i = 0; i < 3; i++) begin
      k = 0;
      while (req_ready !== 1'b1 && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (i > 0) begin
        total++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_accept_in_resp_cycle req=%0d got vld/rdy=%b/%b want=1/1",
                   i, resp_valid, req_ready);
        end
      end
      @(posedge clk);
      #1;
      if (i < 2) begin
        req_cmd  = c[i+1];
        req_data = d[i+1];
      end else begin
        req_valid = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      get_rsp(40, r, ok);
      total++;
      if (!ok || r.d !== e[i] || r.e !== 1'b0 || r.s !== (s0 ^ ~i[0])) begin
        bad++;
        $display("FAIL b2b_resp%0d ok/data/err/sync got=%b/%h/%b/%b want=1/%h/0/%b",
                 i, ok, r.d, r.e, r.s, e[i], s0 ^ ~i[0]);
      end
    end
  endtask

  task automatic test_reset_midop();
    int acc;
    resp_on = 1'b0;
    issue(4'b0001, 8'h05, acc);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus_sync, busy, req_ready, resp_valid, resp_err} !== 5'b00100) begin
      bad++;
      $display("FAIL midop_reset sync/busy/rdy/vld/err got=%b want=00100",
               {bus_sync, busy, req_ready, resp_valid, resp_err});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_tmo = 0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (rq.size() !== 0 || tmo_count !== 8'h00) begin
      bad++;
      $display("FAIL midop_no_pulse pulses/tcnt got=%0d/%0d want=0/0", rq.size(), tmo_count);
    end
    rq.delete();
    resp_on = 1'b1;
    repeat (3) @(negedge clk);
    expect_ok("after_midop_reset", 4'b0001, 8'h03, 1'b1);
  endtask

  task automatic test_saturation();
    int acc;
    rsp_t r;
    logic ok;
    resp_on = 1'b0;
    for (int i = 0; i < 300; i++) begin
      issue(4'b0001, 8'($urandom_range(0, 255)), acc);
      get_rsp(200, r, ok);
      if (n_tmo < 255) n_tmo++;
      total++;
      if (!ok || r.e !== 1'b1 || tmo_count !== 8'(n_tmo)) begin
        bad++;
        $display("FAIL saturate iter=%0d ok/err/tcnt got=%b/%b/%0d want=1/1/%0d",
                 i, ok, r.e, tmo_count, n_tmo);
      end
    end
  endtask

  task automatic test_stale_echo();
    int acc;
    rsp_t r;
    logic ok;
    logic [7:0] exp;
    resp_on = 1'b1;
    repeat (4) @(negedge clk);
    resp_on = 1'b0;
    @(negedge clk);
    stale = ~stale;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || rq.size() !== 0) begin
      bad++;
      $display("FAIL stale_idle busy/pulses got=%b/%0d want=0/0", busy, rq.size());
    end
    exp = model_resp(4'b0001, 8'h03);
    issue(4'b0001, 8'h03, acc);
    resp_on = 1'b1;
    get_rsp(200, r, ok);
    total++;
    if (!ok || r.e !== 1'b0 || r.d !== exp) begin
      bad++;
      $display("FAIL stale_resp ok/err/data got=%b/%b/%h want=1/0/%h", ok, r.e, r.d, exp);
    end
    total++;
    if (tmo_count !== 8'hFF) begin
      bad++;
      $display("FAIL saturate_hold got=%0d want=255", tmo_count);
    end
  endtask

  task automatic test_no_orphan_err();
    total++;
    if (orphan !== 0) begin
      bad++;
      $display("FAIL err_without_valid got=%0d want=0", orphan);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_random();
    test_timeout();
    test_back_to_back();
    test_reset_midop();
    test_saturation();
    test_stale_echo();
    test_no_orphan_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
